// File: rtl/rgb_pwm_pkg.sv
// Shared types and elaboration helpers for the RGB PWM driver.
// Channel identifiers, counter-width helper and per-channel phase offsets.
package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  localparam int NUM_CH               = 3;
  localparam int DEFAULT_PWM_INTERVAL = 1200;

  function automatic int pwm_dw(input int interval);
    int w;
    w = (interval > 1) ? $clog2(interval) : 1;
    return w;
  endfunction

  localparam int DEFAULT_DW = pwm_dw(DEFAULT_PWM_INTERVAL);

  // Spreading on-times across the period lowers the summed LED current peak.
  function automatic int phase_offset(input channel_e ch, input int interval, input bit stagger);
    int off;
    off = 0;
    if (stagger) begin
      case (ch)
        CH_G:    off = interval / 3;
        CH_B:    off = (2 * interval) / 3;
        default: off = 0;
      endcase
    end
    return off;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM channel: double-buffered duty, phase-shifted compare, registered pin.
// Latency 1 cycle from cnt to pin; no backpressure, load is always accepted.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = DEFAULT_PWM_INTERVAL,
  parameter int ACTIVE_LOW   = 1,
  parameter int OFFSET       = 0,
  parameter int DW           = pwm_dw(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          commit,
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] duty,
  output logic          led
);

  localparam logic          INACTIVE = (ACTIVE_LOW != 0);
  localparam logic [DW:0]   OFFSET_W = (DW+1)'(OFFSET);
  localparam logic [DW:0]   PERIOD_W = (DW+1)'(PWM_INTERVAL);

  logic [DW-1:0] pending_duty;
  logic [DW-1:0] active_duty;
  logic [DW:0]   pc_sum;
  logic [DW:0]   pc;
  logic          on;

  // One extra bit keeps cnt + offset from wrapping before the modulo fold.
  always_comb begin
    pc_sum = {1'b0, cnt} + OFFSET_W;
    pc     = pc_sum;
    if (pc_sum >= PERIOD_W) begin
      pc = pc_sum - PERIOD_W;
    end
  end

  // Duties at or above the period stay on every cycle since pc never reaches them.
  assign on = (pc < {1'b0, active_duty});

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_duty <= '0;
      active_duty  <= '0;
      led          <= INACTIVE;
    end else begin
      if (commit) begin
        active_duty <= pending_duty;
      end
      if (load) begin
        pending_duty <= duty;
      end
      led <= en ? (on ^ INACTIVE) : INACTIVE;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Fixed-period RGB PWM with boundary-committed duty updates and optional phase stagger.
// Pins lag the period counter by 1 cycle; no backpressure, duty_load is always accepted.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int  PWM_INTERVAL = DEFAULT_PWM_INTERVAL,
  parameter int  ACTIVE_LOW   = 1,
  parameter int  STAGGER      = 1,
  localparam int DW           = pwm_dw(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] duty_r,
  input  logic [DW-1:0] duty_g,
  input  logic [DW-1:0] duty_b,
  input  logic          duty_load,
  output logic          led_r,
  output logic          led_g,
  output logic          led_b,
  output logic          period_start,
  output logic          update_pending
);

  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);

  logic [DW-1:0] cnt;
  logic          cnt_last;
  logic          commit;
  logic [DW-1:0] duty_vec [NUM_CH];
  logic [NUM_CH-1:0] led_vec;

  assign cnt_last = (cnt == CNT_LAST);
  // Disabled: commit every edge so the block always holds the newest duty.
  assign commit   = !en || cnt_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      period_start   <= 1'b0;
      update_pending <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
      if (!en || cnt_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
      if (duty_load) begin
        update_pending <= 1'b1;
      end else if (commit) begin
        update_pending <= 1'b0;
      end
    end
  end

  assign duty_vec[CH_R] = duty_r;
  assign duty_vec[CH_G] = duty_g;
  assign duty_vec[CH_B] = duty_b;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam channel_e CH  = channel_e'(i);
    localparam int       OFF = phase_offset(CH, PWM_INTERVAL, STAGGER != 0);

    pwm_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .OFFSET       (OFF),
      .DW           (DW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .load   (duty_load),
      .commit (commit),
      .cnt    (cnt),
      .duty   (duty_vec[i]),
      .led    (led_vec[i])
    );
  end

  assign led_r = led_vec[CH_R];
  assign led_g = led_vec[CH_G];
  assign led_b = led_vec[CH_B];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench: per-period on-time windows expected for an unstaggered and a staggered instance.
module tb_rgb_pwm_driver;

  typedef struct packed {
    int n;
    int f;
    int l;
  } ch_t;

  typedef struct packed {
    ch_t  r;
    ch_t  g;
    ch_t  b;
    logic ps;
    logic pm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [10:0] duty_r = '0, duty_g = '0, duty_b = '0;
  logic        duty_load = 1'b0;

  logic ns_r, ns_g, ns_b, ns_ps, ns_up;
  logic st_r, st_g, st_b, st_ps, st_up;

  int checks   = 0;
  int failures = 0;
  int ph       = 0;

  exp_t q_ns [$];
  exp_t q_st [$];

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PWM_INTERVAL(1200), .ACTIVE_LOW(1), .STAGGER(0)) u_ns (
    .clk(clk), .rst(rst), .en(en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_load(duty_load),
    .led_r(ns_r), .led_g(ns_g), .led_b(ns_b),
    .period_start(ns_ps), .update_pending(ns_up)
  );

  rgb_pwm_driver #(.PWM_INTERVAL(1200), .ACTIVE_LOW(1), .STAGGER(1)) u_st (
    .clk(clk), .rst(rst), .en(en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_load(duty_load),
    .led_r(st_r), .led_g(st_g), .led_b(st_b),
    .period_start(st_ps), .update_pending(st_up)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic chk_ch(input string nm, input ch_t act, input ch_t want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got n=%0d first=%0d last=%0d want n=%0d first=%0d last=%0d",
               nm, act.n, act.f, act.l, want.n, want.f, want.l);
    end
  endtask

  function automatic ch_t mk(input int n, input int f, input int l);
    ch_t c;
    c.n = n; c.f = f; c.l = l;
    return c;
  endfunction

  function automatic exp_t mk_exp(input ch_t r, input ch_t g, input ch_t b, input logic ps, input logic pm);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.ps = ps; e.pm = pm;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic [2:0] led_s [2];
  logic       ps_s  [2];
  logic       up_s  [2];
  assign led_s[0] = {ns_b, ns_g, ns_r};
  assign led_s[1] = {st_b, st_g, st_r};
  assign ps_s[0]  = ns_ps;
  assign ps_s[1]  = st_ps;
  assign up_s[0]  = ns_up;
  assign up_s[1]  = st_up;

  int   rn [2][3];
  int   rf [2][3];
  int   rl [2][3];
  int   rlen [2];
  int   prd  [2];
  bit   ropen [2];
  logic rps [2];
  logic rpm [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      ropen[d] = 1'b0;
      prd[d]   = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst || !en) begin
        ropen[d] = 1'b0;
      end else begin
        if (ps_s[d]) begin
          if (ropen[d]) begin
            string tag;
            exp_t  e;
            tag = $sformatf("%s p%0d", (d == 0) ? "ns" : "st", prd[d]);
            prd[d]++;
            if ((d == 0 && q_ns.size() == 0) || (d == 1 && q_st.size() == 0)) begin
              checks++;
              failures++;
              $display("FAIL %s no_expectation: period completed with empty queue", tag);
            end else begin
              e = (d == 0) ? q_ns.pop_front() : q_st.pop_front();
              chk({tag, " len"}, rlen[d], 1200);
              chk_ch({tag, " red"},   mk(rn[d][0], rf[d][0], rl[d][0]), e.r);
              chk_ch({tag, " green"}, mk(rn[d][1], rf[d][1], rl[d][1]), e.g);
              chk_ch({tag, " blue"},  mk(rn[d][2], rf[d][2], rl[d][2]), e.b);
              chk({tag, " pend_start"}, {31'd0, rps[d]}, {31'd0, e.ps});
              chk({tag, " pend_mid"},   {31'd0, rpm[d]}, {31'd0, e.pm});
            end
          end
          ropen[d] = 1'b1;
          rlen[d]  = 0;
          rps[d]   = up_s[d];
          rpm[d]   = 1'b0;
          for (int c = 0; c < 3; c++) begin
            rn[d][c] = 0; rf[d][c] = -1; rl[d][c] = -1;
          end
        end
        if (ropen[d]) begin
          for (int c = 0; c < 3; c++) begin
            if (led_s[d][c] == 1'b0) begin
              if (rn[d][c] == 0) rf[d][c] = rlen[d];
              rl[d][c] = rlen[d];
              rn[d][c]++;
            end
          end
          if (rlen[d] == 600) rpm[d] = up_s[d];
          rlen[d]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    if (rst || !en) ph = 0;
    else            ph = (ph + 1) % 1200;
    #1;
  endtask

  task automatic wait_ph(input int c);
    while (ph != c) step();
  endtask

  task automatic run_to_boundary();
    do step(); while (ph != 0);
  endtask

  task automatic load(input int r, input int g, input int b);
    duty_r = 11'(r); duty_g = 11'(g); duty_b = 11'(b);
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
  endtask

  task automatic push(input exp_t e_ns, input exp_t e_st);
    q_ns.push_back(e_ns);
    q_st.push_back(e_st);
  endtask

  task automatic chk_idle_pins(input string nm, input logic up_want);
    chk({nm, " ns leds"}, {29'd0, ns_b, ns_g, ns_r}, 32'h7);
    chk({nm, " st leds"}, {29'd0, st_b, st_g, st_r}, 32'h7);
    chk({nm, " ns period_start"}, {31'd0, ns_ps}, 32'd0);
    chk({nm, " st period_start"}, {31'd0, st_ps}, 32'd0);
    chk({nm, " ns update_pending"}, {31'd0, ns_up}, {31'd0, up_want});
    chk({nm, " st update_pending"}, {31'd0, st_up}, {31'd0, up_want});
  endtask

  initial begin
    ch_t off, full;
    exp_t e_idle;
    off  = mk(0, -1, -1);
    full = mk(1200, 0, 1199);

    repeat (3) step();
    chk_idle_pins("reset", 1'b0);
    rst = 1'b0;

    // P1: idle after reset
    e_idle = mk_exp(off, off, off, 1'b0, 1'b0);
    push(e_idle, e_idle);
    run_to_boundary();

    // P2: load 200/600/0 at cnt 50, no visible change yet
    push(mk_exp(off, off, off, 1'b0, 1'b1), mk_exp(off, off, off, 1'b0, 1'b1));
    wait_ph(50);
    load(200, 600, 0);
    run_to_boundary();

    // P3: 200/600/0 active; load 200 on all at cnt 100
    push(mk_exp(mk(200, 0, 199), mk(600, 0, 599), off, 1'b0, 1'b1),
         mk_exp(mk(200, 0, 199), mk(600, 0, 1199), off, 1'b0, 1'b1));
    wait_ph(100);
    load(200, 200, 200);
    run_to_boundary();

    // P4: all 200, staggered windows; load boundary duties at cnt 700
    push(mk_exp(mk(200, 0, 199), mk(200, 0, 199), mk(200, 0, 199), 1'b0, 1'b0),
         mk_exp(mk(200, 0, 199), mk(200, 800, 999), mk(200, 400, 599), 1'b0, 1'b0));
    wait_ph(700);
    load(0, 1199, 1500);
    run_to_boundary();

    // P5: boundary duties; load 300 on the commit edge (cnt 1199)
    push(mk_exp(off, mk(1199, 0, 1198), full, 1'b0, 1'b0),
         mk_exp(off, mk(1199, 0, 1199), full, 1'b0, 1'b0));
    wait_ph(1199);
    load(300, 300, 300);

    // P6: prior duty still active, update still pending
    push(mk_exp(off, mk(1199, 0, 1198), full, 1'b1, 1'b1),
         mk_exp(off, mk(1199, 0, 1199), full, 1'b1, 1'b1));
    run_to_boundary();

    // P7: 300 committed at the following boundary
    push(mk_exp(mk(300, 0, 299), mk(300, 0, 299), mk(300, 0, 299), 1'b0, 1'b0),
         mk_exp(mk(300, 0, 299), mk(300, 800, 1099), mk(300, 400, 699), 1'b0, 1'b0));
    run_to_boundary();

    // Disable mid-period: pins inactive, load commits on the next edge
    wait_ph(100);
    en = 1'b0;
    step();
    chk_idle_pins("disabled", 1'b0);
    load(500, 500, 500);
    chk_idle_pins("disabled load", 1'b1);
    step();
    chk_idle_pins("disabled commit", 1'b0);

    // Re-enable: first period is complete and uses 500
    en = 1'b1;
    push(mk_exp(mk(500, 0, 499), mk(500, 0, 499), mk(500, 0, 499), 1'b0, 1'b0),
         mk_exp(mk(500, 0, 499), mk(500, 0, 1199), mk(500, 400, 899), 1'b0, 1'b0));
    run_to_boundary();

    // Mid-period reset at cnt 700
    wait_ph(700);
    rst = 1'b1;
    step();
    chk_idle_pins("mid reset", 1'b0);
    rst = 1'b0;

    // Active duty cleared by reset: a full idle period follows
    push(e_idle, e_idle);
    run_to_boundary();
    step();
    @(negedge clk);
    #1;
    chk("ns queue drained", q_ns.size(), 0);
    chk("st queue drained", q_st.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
